// File: rtl/exe_pkg.sv
// Shared types and constants for the execute-stage ALU arbiter.
package exe_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int FLAG_C = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_Z = 0;

  localparam int OP_W   = 5;
  localparam int FN_W   = 2;
  localparam int FLAG_W = 4;

  localparam logic [OP_W-1:0] ALUOP_ADD = 5'd0;
  localparam logic [OP_W-1:0] ALUOP_SUB = 5'd1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; after a grant the pointer moves to the port that lost.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       idx
);
  logic       r_ptr;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) w_gnt = r_ptr ? 2'b10 : 2'b01;
      else              w_gnt = req;
    end
  end

  assign gnt = w_gnt;
  assign idx = w_gnt[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_ptr <= 1'b0;
    else if (|w_gnt) r_ptr <= ~w_gnt[1];
  end
endmodule

// File: rtl/exe_alu_arb.sv
// Shares one execute-stage ALU between the pipeline port (0) and the aux address port (1).
module exe_alu_arb
  import exe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LAT   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0][OP_W-1:0]      req_op,
  input  logic [1:0][FN_W-1:0]      req_func,
  input  logic [1:0][WIDTH-1:0]     req_a,
  input  logic [1:0][WIDTH-1:0]     req_b,
  output logic [OP_W-1:0]           alu_op,
  output logic [FN_W-1:0]           alu_func,
  output logic [WIDTH-1:0]          alu_a,
  output logic [WIDTH-1:0]          alu_b,
  input  logic [WIDTH-1:0]          alu_out,
  input  logic [FLAG_W-1:0]         alu_flags,
  output logic [1:0]                rsp_valid,
  input  logic [1:0]                rsp_ready,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [FLAG_W-1:0]         rsp_flags,
  output logic                      busy
);
  if (LAT < 1 || LAT > 7) begin : g_bad_lat
    $error("exe_alu_arb: LAT must be in 1..7");
  end

  state_e            r_state;
  logic              r_win;
  logic [2:0]        r_cnt;
  logic [OP_W-1:0]   r_op;
  logic [FN_W-1:0]   r_func;
  logic [WIDTH-1:0]  r_a, r_b, r_data;
  logic [FLAG_W-1:0] r_flags;
  logic [1:0]        r_rsp_valid;
  logic              r_busy;

  logic [1:0] w_gnt;
  logic       w_idx;
  logic       w_en;

  assign w_en = (r_state == IDLE);

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (w_en),
    .req (req_valid),
    .gnt (w_gnt),
    .idx (w_idx)
  );

  // Single FSM block: issue hold registers, latency counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_win       <= 1'b0;
      r_cnt       <= 3'd0;
      r_op        <= '0;
      r_func      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_data      <= '0;
      r_flags     <= '0;
      r_rsp_valid <= 2'b00;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_state <= ISSUE;
            r_win   <= w_idx;
            r_op    <= req_op[w_idx];
            r_func  <= req_func[w_idx];
            r_a     <= req_a[w_idx];
            r_b     <= req_b[w_idx];
            r_cnt   <= 3'(LAT - 1);
            r_busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (LAT == 1) begin
            r_state     <= RESP;
            r_data      <= alu_out;
            r_flags     <= alu_flags;
            r_rsp_valid <= r_win ? 2'b10 : 2'b01;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          // Counter hits zero on this edge: the ALU has now seen LAT cycles of stable inputs.
          if (r_cnt <= 3'd1) begin
            r_state     <= RESP;
            r_data      <= alu_out;
            r_flags     <= alu_flags;
            r_rsp_valid <= r_win ? 2'b10 : 2'b01;
          end
        end
        RESP: begin
          if (rsp_ready[r_win]) begin
            r_state     <= IDLE;
            r_rsp_valid <= 2'b00;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = w_gnt;
  assign alu_op    = r_op;
  assign alu_func  = r_func;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_data;
  assign rsp_flags = r_flags;
  assign busy      = r_busy;
endmodule
